ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipeline.sv | 151 +++++++++++++++
 tb/tb_ctrl_pipeline.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
`ifndef ALU_OPCODE
`define ALU_OPCODE 4
`endif

// Control pipeline EX/MEM/WB carrying decoded flags, with load-use stall and taken-branch flush.
// Latency: an ID bundle reaches WB 3 cycles after capture; stall and flush are combinational.
// Backpressure: stall holds PC and IF/ID for exactly one cycle while EX takes a bubble.
module ctrl_pipeline (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic                   id_reg_dst_flag,
    input  logic                   id_alu_src_flag,
    input  logic                   id_mem_to_reg_flag,
    input  logic                   id_reg_write_flag,
    input  logic                   id_mem_read_flag,
    input  logic                   id_mem_write_flag,
    input  logic                   id_branch_flag,
    input  logic                   id_jump_flag,
    input  logic [`ALU_OPCODE-1:0] id_alu_op,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [4:0]             id_rd,
    input  logic                   id_uses_rt,
    input  logic                   ex_branch_taken,
    output logic                   ex_valid,
    output logic                   ex_reg_dst_flag,
    output logic                   ex_alu_src_flag,
    output logic                   ex_branch_flag,
    output logic                   ex_jump_flag,
    output logic [`ALU_OPCODE-1:0] ex_alu_op,
    output logic                   mem_valid,
    output logic                   mem_read_flag,
    output logic                   mem_write_flag,
    output logic                   wb_valid,
    output logic                   wb_reg_write_flag,
    output logic                   wb_mem_to_reg_flag,
    output logic [4:0]             ex_wreg,
    output logic [4:0]             mem_wreg,
    output logic [4:0]             wb_wreg,
    output logic                   stall,
    output logic                   flush
);

    typedef struct packed {
        logic                   valid;
        logic                   reg_dst;
        logic                   alu_src;
        logic                   mem_to_reg;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
        logic                   branch;
        logic                   jump;
        logic [`ALU_OPCODE-1:0] alu_op;
        logic [4:0]             wreg;
    } ex_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] wreg;
    } mem_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       mem_to_reg;
        logic       reg_write;
        logic [4:0] wreg;
    } wb_ctrl_t;

    ex_ctrl_t  ex_q,  ex_d;
    mem_ctrl_t mem_q, mem_d;
    wb_ctrl_t  wb_q,  wb_d;
    logic      load_use;

    // Register 0 is hardwired, so a load targeting it never creates a dependence.
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.wreg != 5'd0) && id_valid &&
                      ((ex_q.wreg == id_rs) || (id_uses_rt && (ex_q.wreg == id_rt)));

    assign flush = ex_branch_taken & ex_q.valid;
    assign stall = load_use & ~flush;

    always_comb begin
        ex_d = '0;
        if (id_valid && !load_use && !flush) begin
            ex_d.valid      = 1'b1;
            ex_d.reg_dst    = id_reg_dst_flag;
            ex_d.alu_src    = id_alu_src_flag;
            ex_d.mem_to_reg = id_mem_to_reg_flag;
            ex_d.reg_write  = id_reg_write_flag;
            ex_d.mem_read   = id_mem_read_flag;
            ex_d.mem_write  = id_mem_write_flag;
            ex_d.branch     = id_branch_flag;
            ex_d.jump       = id_jump_flag;
            ex_d.alu_op     = id_alu_op;
            ex_d.wreg       = id_reg_dst_flag ? id_rd : id_rt;
        end
    end

    always_comb begin
        mem_d            = '0;
        mem_d.valid      = ex_q.valid;
        mem_d.mem_to_reg = ex_q.mem_to_reg;
        mem_d.reg_write  = ex_q.reg_write;
        mem_d.mem_read   = ex_q.mem_read;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.wreg       = ex_q.wreg;

        wb_d             = '0;
        wb_d.valid       = mem_q.valid;
        wb_d.mem_to_reg  = mem_q.mem_to_reg;
        wb_d.reg_write   = mem_q.reg_write;
        wb_d.wreg        = mem_q.wreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Side-effecting flags are gated by valid so a bubble can never write or redirect.
    assign ex_valid           = ex_q.valid;
    assign ex_reg_dst_flag    = ex_q.reg_dst & ex_q.valid;
    assign ex_alu_src_flag    = ex_q.alu_src & ex_q.valid;
    assign ex_branch_flag     = ex_q.branch & ex_q.valid;
    assign ex_jump_flag       = ex_q.jump & ex_q.valid;
    assign ex_alu_op          = ex_q.alu_op;
    assign ex_wreg            = ex_q.wreg;

    assign mem_valid          = mem_q.valid;
    assign mem_read_flag      = mem_q.mem_read & mem_q.valid;
    assign mem_write_flag     = mem_q.mem_write & mem_q.valid;
    assign mem_wreg           = mem_q.wreg;

    assign wb_valid           = wb_q.valid;
    assign wb_reg_write_flag  = wb_q.reg_write & wb_q.valid;
    assign wb_mem_to_reg_flag = wb_q.mem_to_reg & wb_q.valid;
    assign wb_wreg            = wb_q.wreg;

endmodule

// File: tb/tb_ctrl_pipeline.sv
`ifndef ALU_OPCODE
`define ALU_OPCODE 4
`endif

// Directed bench for ctrl_pipeline: per-cycle stall/flush/EX checks plus a WB retirement scoreboard.
module tb_ctrl_pipeline;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   id_valid;
    logic                   id_reg_dst_flag, id_alu_src_flag, id_mem_to_reg_flag, id_reg_write_flag;
    logic                   id_mem_read_flag, id_mem_write_flag, id_branch_flag, id_jump_flag;
    logic [`ALU_OPCODE-1:0] id_alu_op;
    logic [4:0]             id_rs, id_rt, id_rd;
    logic                   id_uses_rt;
    logic                   ex_branch_taken;
    logic                   ex_valid, ex_reg_dst_flag, ex_alu_src_flag, ex_branch_flag, ex_jump_flag;
    logic [`ALU_OPCODE-1:0] ex_alu_op;
    logic                   mem_valid, mem_read_flag, mem_write_flag;
    logic                   wb_valid, wb_reg_write_flag, wb_mem_to_reg_flag;
    logic [4:0]             ex_wreg, mem_wreg, wb_wreg;
    logic                   stall, flush;

    ctrl_pipeline dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_reg_dst_flag(id_reg_dst_flag), .id_alu_src_flag(id_alu_src_flag),
        .id_mem_to_reg_flag(id_mem_to_reg_flag), .id_reg_write_flag(id_reg_write_flag),
        .id_mem_read_flag(id_mem_read_flag), .id_mem_write_flag(id_mem_write_flag),
        .id_branch_flag(id_branch_flag), .id_jump_flag(id_jump_flag), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .ex_branch_taken(ex_branch_taken),
        .ex_valid(ex_valid), .ex_reg_dst_flag(ex_reg_dst_flag), .ex_alu_src_flag(ex_alu_src_flag),
        .ex_branch_flag(ex_branch_flag), .ex_jump_flag(ex_jump_flag), .ex_alu_op(ex_alu_op),
        .mem_valid(mem_valid), .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
        .wb_valid(wb_valid), .wb_reg_write_flag(wb_reg_write_flag),
        .wb_mem_to_reg_flag(wb_mem_to_reg_flag),
        .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
        .stall(stall), .flush(flush)
    );

    typedef struct {
        logic       rw;
        logic       m2r;
        logic [4:0] wreg;
        int         cyc;
    } wb_exp_t;

    wb_exp_t    exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic       exp_rw, exp_m2r;
    logic [4:0] exp_wreg;
    logic [28+`ALU_OPCODE-1:0] all_out;

    assign all_out = {ex_valid, ex_reg_dst_flag, ex_alu_src_flag, ex_branch_flag, ex_jump_flag,
                      ex_alu_op, mem_valid, mem_read_flag, mem_write_flag, wb_valid,
                      wb_reg_write_flag, wb_mem_to_reg_flag, ex_wreg, mem_wreg, wb_wreg,
                      stall, flush};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Retirement monitor: every valid WB bundle must match the oldest expected entry, on time.
    always @(negedge clk) begin
        wb_exp_t e;
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: actual wreg=%0d required=no retirement", wb_wreg);
            end else begin
                e = exp_q.pop_front();
                chk("wb_bundle", 32'({wb_reg_write_flag, wb_mem_to_reg_flag, wb_wreg}),
                    32'({e.rw, e.m2r, e.wreg}));
                chk("wb_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic id_clear();
        id_valid = 0; id_reg_dst_flag = 0; id_alu_src_flag = 0; id_mem_to_reg_flag = 0;
        id_reg_write_flag = 0; id_mem_read_flag = 0; id_mem_write_flag = 0;
        id_branch_flag = 0; id_jump_flag = 0; id_alu_op = '0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
    endtask

    // Invalid slot whose register fields still name r, so only id_valid prevents a hazard.
    task automatic id_nop(input logic [4:0] r);
        id_clear();
        id_rs = r; id_rt = r; id_uses_rt = 1;
    endtask

    task automatic id_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        id_clear();
        id_valid = 1; id_reg_dst_flag = 1; id_reg_write_flag = 1; id_alu_op = 2;
        id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = 1;
        exp_rw = 1; exp_m2r = 0; exp_wreg = rd;
    endtask

    task automatic id_lw(input logic [4:0] rt, input logic [4:0] rs);
        id_clear();
        id_valid = 1; id_alu_src_flag = 1; id_mem_to_reg_flag = 1; id_reg_write_flag = 1;
        id_mem_read_flag = 1; id_rs = rs; id_rt = rt; id_rd = 5'd31;
        exp_rw = 1; exp_m2r = 1; exp_wreg = rt;
    endtask

    task automatic id_sw(input logic [4:0] rt, input logic [4:0] rs, input logic urt);
        id_clear();
        id_valid = 1; id_alu_src_flag = 1; id_mem_write_flag = 1;
        id_rs = rs; id_rt = rt; id_rd = 5'd30; id_uses_rt = urt;
        exp_rw = 0; exp_m2r = 0; exp_wreg = rt;
    endtask

    task automatic step(input logic e_stall, input logic e_flush, input logic e_exv,
                        input logic [4:0] e_exw, input logic accept, input string name);
        wb_exp_t e;
        @(negedge clk);
        chk({name, "_stall"}, 32'(stall), 32'(e_stall));
        chk({name, "_flush"}, 32'(flush), 32'(e_flush));
        chk({name, "_ex_valid"}, 32'(ex_valid), 32'(e_exv));
        chk({name, "_ex_wreg"}, 32'(ex_wreg), 32'(e_exw));
        if (accept) begin
            e.rw = exp_rw; e.m2r = exp_m2r; e.wreg = exp_wreg; e.cyc = cyc + 3;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; ex_branch_taken = 0; id_nop(5'd0);
        #3 chk("reset_outputs", 32'(all_out), 32'h0);
        @(posedge clk); @(posedge clk); #1 rst = 0;
        chk("reset_release_idle", 32'(all_out), 32'h0);

        // add $3 flows to WB three cycles after capture
        id_add(5'd3, 5'd1, 5'd2);  step(0, 0, 0, 5'd0, 1, "s1_c0");
        chk("s1_alu_op", 32'(ex_alu_op), 32'd2);
        chk("s1_reg_dst", 32'(ex_reg_dst_flag), 32'd1);
        id_nop(5'd0);              step(0, 0, 1, 5'd3, 0, "s1_c1");
        step(0, 0, 0, 5'd0, 0, "s1_c2");
        step(0, 0, 0, 5'd0, 0, "s1_c3");

        // lw $5 then add reading $5: one stall, one bubble, then add proceeds
        id_lw(5'd5, 5'd1);         step(0, 0, 0, 5'd0, 1, "s2_c0");
        id_add(5'd6, 5'd5, 5'd2);  step(1, 0, 1, 5'd5, 0, "s2_c1");
        chk("s2_mem_read", 32'(mem_read_flag), 32'd1);
        step(0, 0, 0, 5'd0, 1, "s2_c2");
        id_nop(5'd0);              step(0, 0, 1, 5'd6, 0, "s2_c3");
        step(0, 0, 0, 5'd0, 0, "s2_c4");
        step(0, 0, 0, 5'd0, 0, "s2_c5");

        // lw $0 then reader of $0: never stalls
        id_lw(5'd0, 5'd1);         step(0, 0, 0, 5'd0, 1, "s3_c0");
        id_add(5'd7, 5'd0, 5'd0);  step(0, 0, 1, 5'd0, 1, "s3_c1");
        id_nop(5'd0);              step(0, 0, 1, 5'd7, 0, "s3_c2");
        step(0, 0, 0, 5'd0, 0, "s3_c3");
        step(0, 0, 0, 5'd0, 0, "s3_c4");

        // lw $5 followed by an invalid slot naming $5: no stall
        id_lw(5'd5, 5'd1);         step(0, 0, 0, 5'd0, 1, "s3b_c0");
        id_nop(5'd5);              step(0, 0, 1, 5'd5, 0, "s3b_c1");
        id_nop(5'd0);              step(0, 0, 0, 5'd0, 0, "s3b_c2");
        step(0, 0, 0, 5'd0, 0, "s3b_c3");

        // taken branch in EX beats the load-use hazard; branch_taken on a bubble does nothing
        id_lw(5'd5, 5'd1);         step(0, 0, 0, 5'd0, 1, "s4_c0");
        id_add(5'd6, 5'd5, 5'd2);  ex_branch_taken = 1;
        step(0, 1, 1, 5'd5, 0, "s4_c1");
        id_nop(5'd0);              step(0, 0, 0, 5'd0, 0, "s4_c2");
        ex_branch_taken = 0;
        step(0, 0, 0, 5'd0, 0, "s4_c3");
        step(0, 0, 0, 5'd0, 0, "s4_c4");

        // sw reading rt=5 after lw $5 stalls only when id_uses_rt is set
        id_lw(5'd5, 5'd1);         step(0, 0, 0, 5'd0, 1, "s5a_c0");
        id_sw(5'd5, 5'd1, 1'b1);   step(1, 0, 1, 5'd5, 0, "s5a_c1");
        step(0, 0, 0, 5'd0, 1, "s5a_c2");
        id_nop(5'd0);              step(0, 0, 1, 5'd5, 0, "s5a_c3");
        step(0, 0, 0, 5'd0, 0, "s5a_c4");
        step(0, 0, 0, 5'd0, 0, "s5a_c5");

        id_lw(5'd5, 5'd1);         step(0, 0, 0, 5'd0, 1, "s5b_c0");
        id_sw(5'd5, 5'd1, 1'b0);   step(0, 0, 1, 5'd5, 1, "s5b_c1");
        id_nop(5'd0);              step(0, 0, 1, 5'd5, 0, "s5b_c2");
        step(0, 0, 0, 5'd0, 0, "s5b_c3");
        step(0, 0, 0, 5'd0, 0, "s5b_c4");

        // async reset with three bundles in flight, then clean restart
        id_add(5'd3, 5'd1, 5'd2);  step(0, 0, 0, 5'd0, 1, "s6_c0");
        id_add(5'd4, 5'd1, 5'd2);  step(0, 0, 1, 5'd3, 1, "s6_c1");
        id_lw(5'd8, 5'd1);         step(0, 0, 1, 5'd4, 1, "s6_c2");
        chk("s6_inflight", 32'({ex_valid, mem_valid, wb_valid}), 32'h7);
        id_add(5'd6, 5'd8, 5'd2);
        #0 chk("s6_pre_stall", 32'(stall), 32'd1);
        #1 rst = 1;
        exp_q.delete();
        #1 chk("s6_rst_zero", 32'(all_out), 32'h0);
        @(posedge clk);
        #1 chk("s6_rst_hold", 32'(all_out), 32'h0);
        rst = 0;
        step(0, 0, 0, 5'd0, 1, "s6_r0");
        id_nop(5'd0);              step(0, 0, 1, 5'd6, 0, "s6_r1");
        step(0, 0, 0, 5'd0, 0, "s6_r2");
        step(0, 0, 0, 5'd0, 0, "s6_r3");
        step(0, 0, 0, 5'd0, 0, "s6_r4");

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
